// File: rtl/seg7_scan_display.sv
// seg7_scan_display: shows a 16-bit unsigned value as decimal on a multiplexed
// 7-segment display. The BCD conversion is sequential (shift-add-3). The divided
// scan clock is only sampled in the clk_in domain. It is never used as a clock.
module seg7_scan_display #(
    parameter int NUM_AN = 8,      // anodes driven, 5..8
    parameter bit LZB    = 1'b1    // 1 = blank leading zeros
) (
    input  logic              clk_in,
    input  logic              rst,       // async, active-low
    input  logic              scan_clk,
    input  logic              load,
    input  logic [15:0]       value,
    output logic              busy,
    output logic [6:0]        seg,       // active-low g..a
    output logic [NUM_AN-1:0] an         // active-low, an[0] rightmost
);

    localparam int IDX_W = $clog2(NUM_AN);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    // active-low gfedcba pattern for one BCD digit
    function automatic logic [6:0] decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    // ---------------- scan tick and scan index ----------------
    // sync_q[0], sync_q[1] form the synchroniser. sync_q[2] holds the previous sample for edge detect.
    logic [2:0]       sync_q, sync_d;
    logic             scan_tick;
    logic [IDX_W-1:0] idx_q, idx_d;

    // Shift scan_clk through the synchroniser. Advance the index on each rising edge.
    always_comb begin
        sync_d    = {sync_q[1:0], scan_clk};
        scan_tick = sync_q[1] & ~sync_q[2];
        idx_d     = idx_q;
        if (scan_tick) begin
            if (idx_q == IDX_W'(NUM_AN - 1)) idx_d = '0;
            else                             idx_d = idx_q + 1'b1;
        end
    end

    // Scan-side state registers.
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            sync_q <= '0;
            idx_q  <= '0;
        end else begin
            sync_q <= sync_d;
            idx_q  <= idx_d;
        end
    end

    // ---------------- binary to BCD conversion ----------------
    state_t      state_q;
    logic [15:0] shift_q;
    logic [19:0] bcd_q;
    logic [19:0] bcd_adj;
    logic [3:0]  cnt_q;
    logic [19:0] disp_q;
    logic        busy_q;

    // Add 3 to every nibble of 5 or more before the shift. The shift then doubles it past 9 into the next decade.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < 5; i++) begin
            if (bcd_q[i*4 +: 4] >= 4'd5) bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
        end
    end

    // Conversion FSM. disp_q changes only in DONE, so the display never shows partial results.
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            shift_q <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            disp_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (load) begin
                        shift_q <= value;
                        bcd_q   <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    {bcd_q, shift_q} <= {bcd_adj[18:0], shift_q, 1'b0};
                    cnt_q            <= cnt_q + 1'b1;
                    if (cnt_q == 4'd15) state_q <= DONE;
                end
                DONE: begin
                    disp_q  <= bcd_q;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // ---------------- digit select, blanking, outputs ----------------
    logic [6:0]        seg_q, seg_d;
    logic [NUM_AN-1:0] an_q, an_d;
    logic [3:0]        dig [5];
    logic [4:0]        zero_from;   // zero_from[i]: digits i..4 are all zero
    logic [3:0]        cur_dig;
    logic              cur_blank;

    // Pick the current slot's digit and decide whether it is blanked.
    always_comb begin
        for (int i = 0; i < 5; i++) dig[i] = disp_q[i*4 +: 4];
        zero_from[4] = (dig[4] == 4'd0);
        for (int i = 3; i >= 0; i--) zero_from[i] = zero_from[i+1] & (dig[i] == 4'd0);

        cur_dig   = 4'd0;
        cur_blank = 1'b1;                    // slots 5 and up stay dark
        for (int i = 0; i < 5; i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_dig   = dig[i];
                cur_blank = LZB && (i > 0) && zero_from[i];
            end
        end

        seg_d = cur_blank ? 7'b1111111 : decode(cur_dig);
        an_d  = '1;
        for (int i = 0; i < NUM_AN; i++) begin
            if (!cur_blank && idx_q == IDX_W'(i)) an_d[i] = 1'b0;
        end
    end

    // Registered segment and anode drivers.
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            seg_q <= 7'b1000000;
            an_q  <= ~NUM_AN'(1);
        end else begin
            seg_q <= seg_d;
            an_q  <= an_d;
        end
    end

    assign seg  = seg_q;
    assign an   = an_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_seg7_scan_display.sv
// Bench for seg7_scan_display. The stimulus pushes the expected slot contents for each
// scan pulse. A monitor pops and compares them once each pulse has propagated.
module tb_seg7_scan_display;

    localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100,
                           S3 = 7'b0110000, S4 = 7'b0011001, S5 = 7'b0010010,
                           S6 = 7'b0000010, S7 = 7'b1111000, BL = 7'b1111111;

    logic        clk_in = 1'b0;
    logic        rst, scan_clk, load;
    logic [15:0] value;
    logic        busy_a, busy_b;
    logic [6:0]  seg_a, seg_b;
    logic [7:0]  an_a, an_b;

    always #5 clk_in = ~clk_in;

    seg7_scan_display #(.NUM_AN(8), .LZB(1'b1)) u_dut (
        .clk_in(clk_in), .rst(rst), .scan_clk(scan_clk), .load(load),
        .value(value), .busy(busy_a), .seg(seg_a), .an(an_a));

    seg7_scan_display #(.NUM_AN(8), .LZB(1'b0)) u_dut_nolzb (
        .clk_in(clk_in), .rst(rst), .scan_clk(scan_clk), .load(load),
        .value(value), .busy(busy_b), .seg(seg_b), .an(an_b));

    typedef struct {
        logic [7:0] an;
        logic [6:0] seg;
        bit         chk_b;
        logic [7:0] an_b;
        logic [6:0] seg_b;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] a, input logic [6:0] s, input bit cb,
                        input logic [7:0] ab, input logic [6:0] sb);
        exp_t e;
        e.an = a; e.seg = s; e.chk_b = cb; e.an_b = ab; e.seg_b = sb;
        sb_q.push_back(e);
    endtask

    // One scan_clk period (6 high, 6 low) with the expected next-slot contents.
    task automatic pulse(input logic [7:0] a, input logic [6:0] s);
        push(a, s, 1'b0, 8'h00, 7'h00);
        scan_clk = 1'b1;
        repeat (6) @(negedge clk_in);
        scan_clk = 1'b0;
        repeat (6) @(negedge clk_in);
    endtask

    task automatic pulse2(input logic [7:0] a, input logic [6:0] s,
                          input logic [7:0] ab, input logic [6:0] sb);
        push(a, s, 1'b1, ab, sb);
        scan_clk = 1'b1;
        repeat (6) @(negedge clk_in);
        scan_clk = 1'b0;
        repeat (6) @(negedge clk_in);
    endtask

    task automatic do_load(input logic [15:0] v);
        load  = 1'b1;
        value = v;
        @(negedge clk_in);
        load  = 1'b0;
    endtask

    // Bounded wait for the end of a conversion, then one cycle for seg/an to refresh.
    task automatic wait_idle(input string name);
        int n = 0;
        while (busy_a && n < 60) begin
            @(negedge clk_in);
            n++;
        end
        chk(name, {31'd0, busy_a}, 32'd0);
        @(negedge clk_in);
    endtask

    // Monitor: each scan rise reaches seg/an after 4 clk_in edges (2 sync, tick->index, index->output).
    initial begin
        exp_t e;
        forever begin
            @(posedge scan_clk);
            repeat (4) @(posedge clk_in);
            @(negedge clk_in);
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL scan_unexpected: got an=%h seg=%b expected no scan event", an_a, seg_a);
            end else begin
                e = sb_q.pop_front();
                chk("scan_an", {24'd0, an_a}, {24'd0, e.an});
                chk("scan_seg", {25'd0, seg_a}, {25'd0, e.seg});
                if (e.chk_b) begin
                    chk("scan_an_nolzb", {24'd0, an_b}, {24'd0, e.an_b});
                    chk("scan_seg_nolzb", {25'd0, seg_b}, {25'd0, e.seg_b});
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b0; scan_clk = 1'b0; load = 1'b0; value = 16'd0;

        // reset state
        repeat (3) @(negedge clk_in);
        chk("rst_an", {24'd0, an_a}, 32'h0000_00FE);
        chk("rst_seg", {25'd0, seg_a}, {25'd0, S0});
        chk("rst_busy", {31'd0, busy_a}, 32'd0);
        rst = 1'b1;
        @(negedge clk_in);

        // display 0: slots 1..7 blank, wrap back to slot 0
        repeat (7) pulse(8'hFF, BL);
        pulse(8'hFE, S0);

        // 65025 -> busy 17 cycles, previous display held meanwhile
        do_load(16'd65025);
        n = 0;
        for (int i = 0; i < 45; i++) begin
            if (i == 8) begin
                chk("hold_an", {24'd0, an_a}, 32'h0000_00FE);
                chk("hold_seg", {25'd0, seg_a}, {25'd0, S0});
            end
            if (busy_a) n++;
            @(negedge clk_in);
        end
        chk("busy_len_65025", n, 32'd17);
        chk("d65025_s0", {25'd0, seg_a}, {25'd0, S5});
        pulse(8'hFD, S2);
        pulse(8'hFB, S0);
        pulse(8'hF7, S5);
        pulse(8'hEF, S6);
        repeat (3) pulse(8'hFF, BL);
        pulse(8'hFE, S5);

        // 7 with and without leading-zero blanking
        do_load(16'd7);
        wait_idle("idle_7");
        chk("d7_an", {24'd0, an_a}, 32'h0000_00FE);
        chk("d7_seg", {25'd0, seg_a}, {25'd0, S7});
        chk("d7_seg_nolzb", {25'd0, seg_b}, {25'd0, S7});
        pulse2(8'hFF, BL, 8'hFD, S0);
        pulse2(8'hFF, BL, 8'hFB, S0);
        pulse2(8'hFF, BL, 8'hF7, S0);
        pulse2(8'hFF, BL, 8'hEF, S0);
        repeat (3) pulse2(8'hFF, BL, 8'hFF, BL);
        pulse2(8'hFE, S7, 8'hFE, S7);

        // 1234, then 9999 while busy is ignored
        do_load(16'd1234);
        n = 0;
        for (int i = 0; i < 45; i++) begin
            if (i == 3) begin
                load = 1'b1; value = 16'd9999;
            end else begin
                load = 1'b0;
            end
            if (busy_a) n++;
            @(negedge clk_in);
        end
        load = 1'b0;
        chk("busy_len_1234", n, 32'd17);
        chk("d1234_s0", {25'd0, seg_a}, {25'd0, S4});
        pulse(8'hFD, S3);

        // scan_clk held high: no further advance; falling edge: no advance
        push(8'hFB, S2, 1'b0, 8'h00, 7'h00);
        scan_clk = 1'b1;
        repeat (100) @(negedge clk_in);
        chk("hold_high_an", {24'd0, an_a}, 32'h0000_00FB);
        scan_clk = 1'b0;
        repeat (50) @(negedge clk_in);
        chk("fall_noadv_an", {24'd0, an_a}, 32'h0000_00FB);

        // exact latency: index moves 3 cycles after the rise, seg/an one cycle later
        push(8'hF7, S1, 1'b0, 8'h00, 7'h00);
        scan_clk = 1'b1;
        repeat (3) @(negedge clk_in);
        chk("lat_before_an", {24'd0, an_a}, 32'h0000_00FB);
        @(negedge clk_in);
        chk("lat_after_an", {24'd0, an_a}, 32'h0000_00F7);
        repeat (46) @(negedge clk_in);
        scan_clk = 1'b0;
        repeat (50) @(negedge clk_in);
        chk("slow_low_an", {24'd0, an_a}, 32'h0000_00F7);
        repeat (4) pulse(8'hFF, BL);
        pulse(8'hFE, S4);

        // reset mid-conversion of 4321
        do_load(16'd4321);
        repeat (7) @(negedge clk_in);
        rst = 1'b0;
        #1;
        chk("rst_mid_busy", {31'd0, busy_a}, 32'd0);
        chk("rst_mid_an", {24'd0, an_a}, 32'h0000_00FE);
        chk("rst_mid_seg", {25'd0, seg_a}, {25'd0, S0});
        chk("rst_mid_an_nolzb", {24'd0, an_b}, 32'h0000_00FE);
        @(negedge clk_in);
        rst = 1'b1;
        repeat (20) @(negedge clk_in);
        chk("post_rst_busy", {31'd0, busy_a}, 32'd0);
        chk("post_rst_seg", {25'd0, seg_a}, {25'd0, S0});
        do_load(16'd4321);
        wait_idle("idle_4321");
        chk("d4321_s0", {25'd0, seg_a}, {25'd0, S1});
        pulse(8'hFD, S2);
        pulse(8'hFB, S3);
        pulse(8'hF7, S4);
        repeat (4) pulse(8'hFF, BL);
        pulse(8'hFE, S1);

        repeat (10) @(negedge clk_in);
        chk("sb_drained", sb_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seg7_scan_display.md
Name: seg7_scan_display

Overview:
Display stage that consumes the divided clock from the clock divider and shows the 16-bit SPM product as unsigned decimal on a multiplexed 7-segment display. Binary-to-BCD conversion is sequential (shift-add-3 over 16 cycles). Digits are scanned one per rising edge of the divided clock. All logic runs in the fast system clock domain; the divided clock is only sampled, never used as a clock.

Parameters:
NUM_AN, 8, number of anodes driven (legal 5..8); slots 5..NUM_AN-1 are always blank.
LZB, 1, leading-zero blanking enable (1 = blank leading zeros, 0 = show all 5 digits).

Ports:
clk_in  input  1  system clock.
rst  input  1  reset, asynchronous, active-low.
scan_clk  input  1  divided clock from the clock divider (square wave).
load  input  1  single-cycle request to convert and display value.
value  input  16  unsigned product to display.
busy  output  1  high while a conversion is in progress.
seg  output  7  segment cathodes, active-low, seg[6:0] = g,f,e,d,c,b,a.
an  output  NUM_AN  digit anodes, active-low, an[0] = rightmost digit.

Behaviour:
- Reset (rst low, asynchronous): display register = 0; scan index = 0; FSM = IDLE; busy = 0; scan_clk synchroniser = 0; an = all ones except an[0] = 0; seg = 1000000 ("0").
- Scan tick: scan_clk passes through a 2-FF synchroniser followed by rising-edge detect, giving a 1-cycle scan_tick. Latency is 3 clk_in cycles from the scan_clk rise. Falling edges and a constant scan_clk do not advance the scan.
- Scan index: width ceil(log2(NUM_AN)). Increments on scan_tick and wraps from NUM_AN-1 to 0. seg/an are registered and update the cycle after the index changes.
- Slot i < 5: an[i] = 0 and seg = decode(BCD digit i), unless the slot is blanked. When a slot is blanked, an = all ones and seg = 1111111.
- Leading-zero blanking (LZB = 1): slot i > 0 is blanked if digits i..4 are all zero. Digit 0 is never blanked.
- Slots >= 5: always blanked.
- Decode table (active-low gfedcba):
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001
  - 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000
- Conversion FSM:
  - IDLE: on load, capture value into the shift register, clear the 20-bit BCD accumulator, busy <= 1, go to SHIFT.
  - SHIFT: 16 cycles. Each cycle, every BCD nibble >= 5 gets +3, then {bcd, shift} shifts left by 1. After the 16th shift, go to DONE.
  - DONE: display register <= BCD, busy <= 0, return to IDLE.
  - busy is high for exactly 17 cycles: it rises the cycle after load and falls on the cycle the display register updates.
- load while busy: ignored, with no queueing.
- The display register holds the previous value for the whole conversion, so there is no glitch on seg/an.
- load and scan_tick in the same cycle: both take effect independently.
- rst low mid-conversion: the conversion is aborted and all state returns to reset values. The next load after rst is released converts normally.

Test Plan:
- Apply and release reset -> an = ...11111110, seg = 1000000, busy = 0. Toggling scan_clk then cycles an through FE, FD (blank, an = FF), and so on.
- load value = 65025 -> busy high 17 cycles. Over 8 scan ticks:
  - an = FE, seg = 0010010 (5)
  - an = FD, seg = 0100100 (2)
  - an = FB, seg = 1000000 (0)
  - an = F7, seg = 0010010 (5)
  - an = EF, seg = 0000010 (6)
  - then an = FF for 3 slots.
- load value = 7 with LZB = 1 -> slot 0 shows 1111000 and slots 1-7 are an = FF. With LZB = 0 -> slots 1-4 show 1000000.
- load 1234, then load 9999 four cycles later while busy -> final display 1,2,3,4; no second conversion; busy total 17 cycles.
- scan_clk held high for 100 cycles -> index frozen. scan_clk toggling every 50 cycles -> exactly one advance per rising edge, occurring 3 cycles after the edge.
- rst low at SHIFT cycle 8 of converting 4321 -> immediate reset outputs, display 0. After release, load 4321 -> shows 4,3,2,1.
